cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle Moore FSM that sequences the 16-bit CPU datapath.
- Runs fetch/decode/execute:
  - drives program-counter and instruction-register controls;
  - drives data-memory address and write enable;
  - drives register-file read/write addresses, write enable and write-data mux select;
  - drives the ALU function select.
- Sits beside the datapath and takes only the current instruction word as input.

Parameters:
- DADDR_W, 8, width of the data-memory address field (IR[11:4]).
- ALU_ADD, 3'd1, ALU_s0 code for add.
- ALU_SUB, 3'd2, ALU_s0 code for subtract.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IR  in  16  current instruction register contents.
- PC_clr  out  1  clear program counter to 0.
- IR_ld  out  1  load IR from instruction memory at next edge.
- PC_up  out  1  increment program counter.
- D_addr  out  DADDR_W  data-memory address.
- D_wr  out  1  data-memory write enable.
- RF_s  out  1  register-file write-data mux select: 1 = memory, 0 = ALU.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file A read address.
- RF_Rb_addr  out  4  register-file B read address.
- ALU_s0  out  3  ALU function select (0 = pass/none).
- state  out  4  current state encoding, for debug and bench.

Behaviour:
- Instruction format (opcode = IR[15:12]):
  - NOOP 0000.
  - STORE 0001: addr = IR[11:4], ra = IR[3:0]; mem[addr] <= R[ra].
  - LOAD 0010: addr = IR[11:4], rd = IR[3:0]; R[rd] <= mem[addr].
  - ADD 0011: ra = IR[11:8], rb = IR[7:4], rd = IR[3:0]; R[rd] <= R[ra] + R[rb].
  - SUB 0100: same fields as ADD; R[rd] <= R[ra] - R[rb].
  - HALT 0101.
  - Opcodes 0110-1111 are treated as NOOP.
- State register:
  - rst_n low forces state = INIT asynchronously.
  - State updates only on rising clk while rst_n is high.
- Outputs are combinational from state and IR only (Moore w.r.t. the FSM). Any output not listed below is 0 in that state.
- State encodings and outputs:
  - INIT = 0: PC_clr = 1. Next state FETCH.
  - FETCH = 1: IR_ld = 1, PC_up = 1. Next state DECODE.
  - DECODE = 2: all control outputs 0. Next state by opcode: NOOP, STORE, LOAD_A, ADD, SUB or HALT; undefined opcodes go to NOOP.
  - NOOP = 3: all 0. Next state FETCH.
  - LOAD_A = 4: D_addr = IR[11:4], RF_s = 1. Next state LOAD_B. This cycle covers the synchronous memory read latency.
  - LOAD_B = 5: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 1. Next state FETCH.
  - STORE = 6: D_addr = IR[11:4], RF_Ra_addr = IR[3:0], D_wr = 1. Next state FETCH.
  - ADD = 7: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], RF_W_en = 1, RF_s = 0, ALU_s0 = ALU_ADD. Next state FETCH.
  - SUB = 8: same as ADD with ALU_s0 = ALU_SUB. Next state FETCH.
  - HALT = 9: all 0. Stays in HALT until reset.
  - Encodings 10-15 are illegal: next state INIT; outputs as INIT.
- Latency (rising edges from FETCH back to FETCH):
  - NOOP / STORE / ADD / SUB: 3 edges (FETCH, DECODE, EXEC).
  - LOAD: 4 edges.
- Reset values, while rst_n is low: state = 0, PC_clr = 1, every other output 0 (D_addr and all addresses = 0, ALU_s0 = 0).
- RF_W_en and D_wr are never both 1 in the same cycle.
- RF_W_en is asserted for exactly one cycle per LOAD/ADD/SUB.
- IR_ld is asserted only in FETCH.
- Reset mid-instruction, including between LOAD_A and LOAD_B: write enables drop immediately (asynchronously) and no write occurs; the FSM restarts at INIT.
- IR changing in any state other than DECODE does not alter the state sequence. Execute-state outputs follow the IR value present at that time; the datapath holds IR constant outside FETCH.

Test Plan:
- Assert rst_n = 0 for 2 cycles, then release -> while low: state = 0, PC_clr = 1, others 0. After release: state sequence 0 -> 1 -> 2, with IR_ld = PC_up = 1 only during state 1.
- IR = 16'h2A35 (LOAD addr 0xA3 -> R5) -> LOAD_A then LOAD_B, both with D_addr = 8'hA3 and RF_s = 1. RF_W_en = 1 with RF_W_addr = 5 only in LOAD_B. Then FETCH; 4 edges total.
- IR = 16'h1B27 (STORE R7 -> addr 0xB2) -> one STORE cycle with D_wr = 1, D_addr = 8'hB2, RF_Ra_addr = 7, RF_W_en = 0. Then FETCH.
- IR = 16'h3123 then 16'h4456 -> ADD cycle: Ra = 1, Rb = 2, W_addr = 3, ALU_s0 = 1, RF_W_en = 1, RF_s = 0. SUB cycle: Ra = 4, Rb = 5, W_addr = 6, ALU_s0 = 2.
- IR = 16'hF000, then 16'h0000, then 16'h5000 -> F000 and 0000 each pass through NOOP (state 3) with all outputs 0. 5000 enters HALT (state 9) and remains there 20 cycles with no enables; a later rst_n pulse returns state to 0.
- In LOAD_A with IR = 16'h2A35, drop rst_n for half a cycle -> state = 0 immediately; RF_W_en is never asserted; after release the sequence is INIT -> FETCH.

Source files
------------

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_unit
// Purpose  : Moore FSM sequencing fetch/decode/execute for the 16-bit datapath.
// Revision : 1.0
// ============================================================================
module cpu_control_unit #(
   parameter int         DADDR_W = 8,
   parameter logic [2:0] ALU_ADD = 3'd1,
   parameter logic [2:0] ALU_SUB = 3'd2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        IR,
   output logic               PC_clr,
   output logic               IR_ld,
   output logic               PC_up,
   output logic [DADDR_W-1:0] D_addr,
   output logic               D_wr,
   output logic               RF_s,
   output logic [3:0]         RF_W_addr,
   output logic               RF_W_en,
   output logic [3:0]         RF_Ra_addr,
   output logic [3:0]         RF_Rb_addr,
   output logic [2:0]         ALU_s0,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] c_OP_NOOP  = 4'b0000;
   localparam logic [3:0] c_OP_STORE = 4'b0001;
   localparam logic [3:0] c_OP_LOAD  = 4'b0010;
   localparam logic [3:0] c_OP_ADD   = 4'b0011;
   localparam logic [3:0] c_OP_SUB   = 4'b0100;
   localparam logic [3:0] c_OP_HALT  = 4'b0101;

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           w_op;
   logic [DADDR_W-1:0]   w_daddr;

   assign w_op    = IR[15:12];
   assign w_daddr = IR[DADDR_W+3:4];
   assign state   = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_INIT;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = S_INIT;
      PC_clr     = 1'b0;
      IR_ld      = 1'b0;
      PC_up      = 1'b0;
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = 4'd0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = 4'd0;
      RF_Rb_addr = 4'd0;
      ALU_s0     = 3'd0;
      case (r_state)
         S_INIT: begin
            PC_clr = 1'b1;
            w_next = S_FETCH;
         end
         S_FETCH: begin
            IR_ld  = 1'b1;
            PC_up  = 1'b1;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            case (w_op)
               c_OP_STORE: w_next = S_STORE;
               c_OP_LOAD:  w_next = S_LOAD_A;
               c_OP_ADD:   w_next = S_ADD;
               c_OP_SUB:   w_next = S_SUB;
               c_OP_HALT:  w_next = S_HALT;
               default:    w_next = S_NOOP;
            endcase
         end
         S_NOOP: w_next = S_FETCH;
         // LOAD_A only waits out the synchronous memory read
         S_LOAD_A: begin
            D_addr = w_daddr;
            RF_s   = 1'b1;
            w_next = S_LOAD_B;
         end
         S_LOAD_B: begin
            D_addr    = w_daddr;
            RF_s      = 1'b1;
            RF_W_addr = IR[3:0];
            RF_W_en   = 1'b1;
            w_next    = S_FETCH;
         end
         S_STORE: begin
            D_addr     = w_daddr;
            RF_Ra_addr = IR[3:0];
            D_wr       = 1'b1;
            w_next     = S_FETCH;
         end
         S_ADD, S_SUB: begin
            RF_Ra_addr = IR[11:8];
            RF_Rb_addr = IR[7:4];
            RF_W_addr  = IR[3:0];
            RF_W_en    = 1'b1;
            ALU_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
            w_next     = S_FETCH;
         end
         S_HALT: w_next = S_HALT;
         default: begin
            // Illegal encodings recover through INIT
            PC_clr = 1'b1;
            w_next = S_INIT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_unit
// Purpose  : Directed self-checking bench for cpu_control_unit.
// Revision : 1.0
// ============================================================================
module tb_cpu_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] IR;
   logic        PC_clr, IR_ld, PC_up, D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
   logic [2:0]  ALU_s0;

   int errors = 0;
   int checks = 0;

   cpu_control_unit #(.DADDR_W(8), .ALU_ADD(3'd1), .ALU_SUB(3'd2)) dut (
      .clk(clk), .rst_n(rst_n), .IR(IR),
      .PC_clr(PC_clr), .IR_ld(IR_ld), .PC_up(PC_up),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
      .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
      .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
      .ALU_s0(ALU_s0), .state(state)
   );

   always #5 clk = ~clk;

   // {state, PC_clr, IR_ld, PC_up, D_addr, D_wr, RF_s, W_addr, W_en, Ra, Rb, ALU}
   logic [32:0] obs;
   assign obs = {state, PC_clr, IR_ld, PC_up, D_addr, D_wr, RF_s,
                 RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};

   function automatic logic [32:0] ev(input logic [3:0] st, input logic pcclr,
                                      input logic irld, input logic pcup,
                                      input logic [7:0] da, input logic dwr,
                                      input logic rfs, input logic [3:0] wa,
                                      input logic wen, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [2:0] alu);
      return {st, pcclr, irld, pcup, da, dwr, rfs, wa, wen, ra, rb, alu};
   endfunction

   task automatic check(input string tag, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [32:0] E_INIT  = 33'h0_0000_0000 | (33'd1 << 28);
   localparam logic [32:0] E_FETCH = {4'd1, 1'b0, 1'b1, 1'b1, 26'd0};
   localparam logic [32:0] E_DEC   = {4'd2, 29'd0};
   localparam logic [32:0] E_NOOP  = {4'd3, 29'd0};
   localparam logic [32:0] E_HALT  = {4'd9, 29'd0};

   // Invariants sampled every cycle
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         assert (!(RF_W_en && D_wr) && (!IR_ld || state == 4'd1)) else begin
            errors++;
            $error("FAIL invariant: state=%0d W_en=%b D_wr=%b IR_ld=%b", state, RF_W_en, D_wr, IR_ld);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      IR    = 16'h0000;
      @(negedge clk);
      check("reset_c1", E_INIT);
      @(negedge clk);
      check("reset_c2", E_INIT);
      rst_n = 1'b1;
      IR    = 16'h2A35;
      #1 check("init_after_release", E_INIT);

      // LOAD 0xA3 -> R5
      step(); check("load_fetch", E_FETCH);
      step(); check("load_decode", E_DEC);
      step(); check("load_a", ev(4'd4,0,0,0,8'hA3,0,1,4'd0,0,4'd0,4'd0,3'd0));
      step(); check("load_b", ev(4'd5,0,0,0,8'hA3,0,1,4'd5,1,4'd0,4'd0,3'd0));
      step(); check("load_back_fetch", E_FETCH);

      // STORE R7 -> 0xB2
      IR = 16'h1B27;
      step(); check("store_decode", E_DEC);
      step(); check("store", ev(4'd6,0,0,0,8'hB2,1,0,4'd0,0,4'd7,4'd0,3'd0));
      step(); check("store_back_fetch", E_FETCH);

      // ADD R3 = R1 + R2
      IR = 16'h3123;
      step(); step(); check("add", ev(4'd7,0,0,0,8'h00,0,0,4'd3,1,4'd1,4'd2,3'd1));
      step(); check("add_back_fetch", E_FETCH);

      // SUB R6 = R4 - R5
      IR = 16'h4456;
      step(); step(); check("sub", ev(4'd8,0,0,0,8'h00,0,0,4'd6,1,4'd4,4'd5,3'd2));
      step(); check("sub_back_fetch", E_FETCH);

      // Undefined opcode and real NOOP
      IR = 16'hF000;
      step(); step(); check("noop_undef", E_NOOP);
      step(); check("noop_undef_fetch", E_FETCH);
      IR = 16'h0000;
      step(); step(); check("noop", E_NOOP);
      step(); check("noop_fetch", E_FETCH);

      // HALT holds for 20 cycles
      IR = 16'h5000;
      step(); check("halt_decode", E_DEC);
      for (int i = 0; i < 20; i++) begin
         step(); check($sformatf("halt_%0d", i), E_HALT);
      end
      #2 rst_n = 1'b0;
      #1 check("halt_async_reset", E_INIT);
      @(negedge clk);
      rst_n = 1'b1;
      IR    = 16'h2A35;
      #1 check("halt_reset_init", E_INIT);

      // Reset pulse in LOAD_A: no write, restart at INIT
      step(); check("r2_fetch", E_FETCH);
      step(); check("r2_decode", E_DEC);
      step(); check("r2_load_a", ev(4'd4,0,0,0,8'hA3,0,1,4'd0,0,4'd0,4'd0,3'd0));
      #1 rst_n = 1'b0;
      #1 check("midload_async_reset", E_INIT);
      @(posedge clk);
      #1 check("midload_held_through_edge", E_INIT);
      rst_n = 1'b1;
      @(negedge clk);
      check("midload_init", E_INIT);
      step(); check("midload_fetch", E_FETCH);
      step(); check("midload_decode", E_DEC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
